// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// helper that turns operand width and digit size into an ADD cycle count.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of ADD cycles needed to consume a WIDTH-bit operand DIGIT bits at a time.
    function automatic int digit_cycles(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width: one bit wider than strictly needed so the last count fits comfortably.
    function automatic int count_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder; the serial adder chains DIGIT of these
// into a ripple slice.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of a single bit position.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: {Co,S} = A + B + Ci, processed DIGIT bits per clock
// through a ripple slice of full_adder_cell and one registered carry.
// Handshake: start is accepted in IDLE or DONE, busy is high in ADD, done
// pulses for one cycle in DONE.  S/Co only change when a result completes.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a Sub input that turns
// the operation into A - B (Co=1 meaning no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    localparam int NCYC = digit_cycles(WIDTH, DIGIT);
    localparam int CW   = count_width(NCYC);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   res_r;
    logic [WIDTH-1:0]   res_next_s;
    logic [DIGIT-1:0]   sum_s;
    logic [DIGIT:0]     chain_s;
    logic [WIDTH-1:0]   b_cap_s;
    logic               c_cap_s;
    logic               accept_s;
    logic               last_s;
    logic               busy_next_s;
    logic               done_next_s;

    // Ripple slice: DIGIT cells fed by the low operand bits and the carry register.
    assign chain_s[0] = carry_r;
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a_r[i]),
            .b  (b_r[i]),
            .ci (chain_s[i]),
            .s  (sum_s[i]),
            .co (chain_s[i+1])
        );
    end

    // Operand B and initial carry as they are loaded on an accepted start.
    always_comb begin
        b_cap_s = B;
        c_cap_s = Ci;
`ifdef SERIAL_ADDER_SUB_EN
        if (Sub) begin
            // Two's complement subtraction: A + ~B + 1.
            b_cap_s = ~B;
            c_cap_s = 1'b1;
        end else begin
            b_cap_s = B;
            c_cap_s = Ci;
        end
`endif
    end

    // Handshake qualifiers and the next partial result (new digit enters at the MSB end).
    always_comb begin
        accept_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        last_s     = (state_r == ST_ADD) && (cnt_r == CNT_LAST);
        res_next_s = WIDTH'({sum_s, res_r} >> DIGIT);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ADD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ADD;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next_s = ST_ADD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode, taken from the next state so busy/done can be registered.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            ST_ADD:  busy_next_s = 1'b1;
            ST_DONE: done_next_s = 1'b1;
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs; reset drops them at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next_s;
            done <= done_next_s;
        end
    end

    // Operand shift registers, carry register, digit counter and partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
            res_r   <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            a_r     <= A;
            b_r     <= b_cap_s;
            carry_r <= c_cap_s;
            cnt_r   <= CNT_ZERO;
        end else if (state_r == ST_ADD) begin
            a_r     <= a_r >> DIGIT;
            b_r     <= b_r >> DIGIT;
            carry_r <= chain_s[DIGIT];
            cnt_r   <= cnt_r + CNT_ONE;
            res_r   <= res_next_s;
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
            res_r   <= res_r;
        end
    end

    // Visible result: loaded only as the final digit completes, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            S  <= {WIDTH{1'b0}};
            Co <= 1'b0;
        end else if (last_s) begin
            S  <= res_next_s;
            Co <= chain_s[DIGIT];
        end else begin
            S  <= S;
            Co <= Co;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (8/1, 8/4, 3/1),
// randomized and directed operations checked against a plain-arithmetic model.
module tb_serial_adder;

    localparam int F_BUSY = 0;
    localparam int F_DONE = 1;
    localparam int F_S    = 2;
    localparam int F_CO   = 3;

    logic clk = 1'b0;
    logic reset;

    logic       start0, start1, start2;
    logic [7:0] a0, b0, a1, b1;
    logic [2:0] a2, b2;
    logic       ci0, ci1, ci2;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub0, sub1, sub2;
`endif
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [7:0] s0, s1;
    logic [2:0] s2;
    logic       co0, co1, co2;

    int n_cmp = 0;
    int n_err = 0;
    int prev_s  [3];
    int prev_co [3];
    int exp_s;
    int exp_co;
    int cur_sub;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .A(a0), .B(b0), .Ci(ci0),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub(sub0),
`endif
        .busy(busy0), .done(done0), .S(s0), .Co(co0)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1), .Ci(ci1),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub(sub1),
`endif
        .busy(busy1), .done(done1), .S(s1), .Co(co1)
    );

    serial_adder #(.WIDTH(3), .DIGIT(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .A(a2), .B(b2), .Ci(ci2),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub(sub2),
`endif
        .busy(busy2), .done(done2), .S(s2), .Co(co2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int wbits(input int w);
        return (w == 2) ? 3 : 8;
    endfunction

    function automatic int ncyc(input int w);
        case (w)
            0: return 8;
            1: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int rand_sub();
`ifdef SERIAL_ADDER_SUB_EN
        return int'($urandom_range(0, 1));
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] rd(input int w, input int what);
        logic [31:0] v;
        v = 32'd0;
        case (w)
            0: case (what)
                F_BUSY: v = {31'd0, busy0};
                F_DONE: v = {31'd0, done0};
                F_S:    v = {24'd0, s0};
                default: v = {31'd0, co0};
            endcase
            1: case (what)
                F_BUSY: v = {31'd0, busy1};
                F_DONE: v = {31'd0, done1};
                F_S:    v = {24'd0, s1};
                default: v = {31'd0, co1};
            endcase
            default: case (what)
                F_BUSY: v = {31'd0, busy2};
                F_DONE: v = {31'd0, done2};
                F_S:    v = {29'd0, s2};
                default: v = {31'd0, co2};
            endcase
        endcase
        return v;
    endfunction

    // Reference: unsigned sum with carry out, or difference with no-borrow flag.
    task automatic model(input int w, input int a, input int b, input int ci, input int sub);
        int mask;
        int t;
        mask = (1 << wbits(w)) - 1;
        if (sub != 0) begin
            exp_s  = (a - b) & mask;
            exp_co = (a >= b) ? 1 : 0;
        end else begin
            t      = a + b + ci;
            exp_s  = t & mask;
            exp_co = (t >> wbits(w)) & 1;
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b, input logic ci);
        case (w)
            0: begin start0 = st; a0 = a; b0 = b; ci0 = ci; end
            1: begin start1 = st; a1 = a; b1 = b; ci1 = ci; end
            default: begin start2 = st; a2 = a[2:0]; b2 = b[2:0]; ci2 = ci; end
        endcase
`ifdef SERIAL_ADDER_SUB_EN
        case (w)
            0: sub0 = cur_sub[0];
            1: sub1 = cur_sub[0];
            default: sub2 = cur_sub[0];
        endcase
`endif
    endtask

    // Present one operation with start high for exactly one accepting edge.
    task automatic launch(input int w, input int a, input int b, input int ci, input int sub);
        int mask;
        mask = (1 << wbits(w)) - 1;
        cur_sub = sub;
        model(w, a & mask, b & mask, ci & 1, sub);
        drive(w, 1'b1, 8'(a), 8'(b), 1'(ci));
        @(posedge clk); #1;
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    // Follow the operation to its done pulse and check timing and result.
    task automatic wait_result(input int w, input int noise);
        int lat;
        int nb;
        int first;
        lat = 0;
        nb = 0;
        first = 1;
        while (rd(w, F_DONE) == 32'd0 && lat < 40) begin
            if (rd(w, F_BUSY) != 32'd0) nb++;
            if (first != 0) begin
                check_eq("hold_s", rd(w, F_S), 32'(prev_s[w]));
                check_eq("hold_co", rd(w, F_CO), 32'(prev_co[w]));
                first = 0;
            end
            if (noise != 0) drive(w, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            @(posedge clk); #1;
            lat++;
        end
        if (noise != 0) drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        check_eq("latency", 32'(lat), 32'(ncyc(w)));
        check_eq("busy_cycles", 32'(nb), 32'(ncyc(w)));
        check_eq("sum", rd(w, F_S), 32'(exp_s));
        check_eq("carry", rd(w, F_CO), 32'(exp_co));
        check_eq("busy_in_done", rd(w, F_BUSY), 32'd0);
        prev_s[w]  = exp_s;
        prev_co[w] = exp_co;
    endtask

    task automatic idle_step(input int w);
        @(posedge clk); #1;
        check_eq("done_pulse", rd(w, F_DONE), 32'd0);
        check_eq("idle_busy", rd(w, F_BUSY), 32'd0);
        check_eq("idle_s", rd(w, F_S), 32'(prev_s[w]));
    endtask

    initial begin
        int ndone;
        reset = 1'b1;
        cur_sub = 0;
        for (int i = 0; i < 3; i++) begin
            prev_s[i] = 0;
            prev_co[i] = 0;
            drive(i, 1'b0, 8'd0, 8'd0, 1'b0);
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_busy", rd(i, F_BUSY), 32'd0);
            check_eq("rst_done", rd(i, F_DONE), 32'd0);
            check_eq("rst_s", rd(i, F_S), 32'd0);
            check_eq("rst_co", rd(i, F_CO), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed: carry ripples through all bits.
        launch(0, 32'hFF, 32'h01, 0, 0);
        wait_result(0, 0);
        idle_step(0);

        // Directed: four-bit digits, two ADD cycles.
        launch(1, 32'h5A, 32'h3C, 1, 0);
        wait_result(1, 0);
        idle_step(1);

        // Back-to-back: second start presented during the DONE cycle.
        launch(0, 32'hA5, 32'h11, 0, 0);
        wait_result(0, 0);
        launch(0, 32'h10, 32'h20, 0, 0);
        wait_result(0, 0);
        idle_step(0);

        // Reset during ADD cycle 3 discards the operation.
        launch(0, 32'h3C, 32'h4B, 1, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check_eq("midrst_busy", rd(0, F_BUSY), 32'd0);
        check_eq("midrst_done", rd(0, F_DONE), 32'd0);
        check_eq("midrst_s", rd(0, F_S), 32'd0);
        check_eq("midrst_co", rd(0, F_CO), 32'd0);
        for (int i = 0; i < 3; i++) begin
            prev_s[i] = 0;
            prev_co[i] = 0;
        end
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done0) ndone++;
        end
        check_eq("no_done_after_rst", 32'(ndone), 32'd0);
        launch(0, 32'hC3, 32'h5E, 1, 0);
        wait_result(0, 0);
        idle_step(0);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtraction with and without borrow.
        launch(0, 32'h05, 32'h07, 1, 1);
        wait_result(0, 0);
        idle_step(0);
        launch(0, 32'h07, 32'h05, 0, 1);
        wait_result(0, 0);
        idle_step(0);
        launch(1, 32'h05, 32'h07, 0, 1);
        wait_result(1, 0);
        idle_step(1);
`endif

        // Random operations on the bit-serial instance, with start noise during ADD.
        for (int n = 0; n < 60; n++) begin
            launch(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 1)), rand_sub());
            wait_result(0, n % 2);
            if ($urandom_range(0, 1) == 1) idle_step(0);
        end

        // Random operations on the four-bit-digit instance.
        for (int n = 0; n < 40; n++) begin
            launch(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 1)), rand_sub());
            wait_result(1, n % 3 == 0 ? 1 : 0);
            if ($urandom_range(0, 1) == 1) idle_step(1);
        end

        // Exhaustive 3-bit additions.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    launch(2, a, b, c, 0);
                    wait_result(2, 0);
                    if (((a + b + c) % 2) == 1) idle_step(2);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle successor to the single-bit combinational full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through a chain of DIGIT full-adder cells and one registered carry.
- Start/busy/done handshake; result held until the next start.
- Used as the area-cheap arithmetic unit in later datapath work and as the first clocked block in the adder test-bench family.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be a positive multiple of DIGIT.
- DIGIT, 1, bits processed per clock; full-adder cells in the slice.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled when not busy
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- Ci  input  1  carry-in, captured on accepted start
- busy  output  1  high while in ADD
- done  output  1  one-cycle pulse when result is valid
- S  output  WIDTH  sum, registered
- Co  output  1  carry-out, registered

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE; busy=0; done=0; S=0; Co=0; internal operand registers, carry register and cycle counter all 0.
- Reset mid-operation: the same immediate clear; the partial result is discarded and no done pulse is issued.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 captures A, B and Ci into the shift registers and carry register.
  - Clears counter and goes to ADD.
  - start=0 stays in IDLE.
- ADD:
  - Each cycle, DIGIT cells add the low DIGIT bits of the A and B shift registers with the carry register.
  - The DIGIT sum bits shift into the result register from the MSB end.
  - The cell-chain carry-out updates the carry register.
  - Operands shift right by DIGIT.
  - Counter increments; after WIDTH/DIGIT cycles go to DONE.
- DONE:
  - S holds the full sum in correct bit order; Co holds the final carry.
  - done=1 for exactly this cycle.
  - Next state is IDLE, or ADD if start=1 (back-to-back accept; new operands captured).
- busy=1 exactly in ADD. start while busy is ignored: no recapture, no restart.
- Latency: an accepted start at edge k gives done=1 during the cycle after edge k+WIDTH/DIGIT.
- S/Co update only on the DONE transition, so they stay stable through ADD and IDLE until the next result.
- Arithmetic: {Co,S} = A + B + Ci modulo 2^(WIDTH+1), unsigned.
- Counter width: clog2(WIDTH/DIGIT)+1.
- WIDTH==DIGIT degenerates to one ADD cycle.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port Sub (1 bit), captured with the operands.
  - Sub=1 captures ~B and forces the initial carry to 1, ignoring Ci; result is S = A - B, with Co=1 meaning no borrow.
  - Sub=0 behaves exactly as the base block.
- Undefined: no Sub port; addition only.

Decomposition:
- Shared package serial_adder_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2;
  - localparam helper for cycle count WIDTH/DIGIT.
- One natural sub-module, full_adder_cell: combinational 1-bit A, B, Ci -> S, Co, instantiated DIGIT times in a generate loop as a ripple slice.

Test Plan:
- WIDTH=8, DIGIT=1; A=8'hFF, B=8'h01, Ci=0, start pulse -> busy for 8 cycles, done one cycle later, S=8'h00, Co=1.
- WIDTH=8, DIGIT=4; A=8'h5A, B=8'h3C, Ci=1 -> done after 2 ADD cycles, S=8'h97, Co=0.
- WIDTH=3, DIGIT=1; exhaustive: all 128 combinations of A, B and Ci, each compared to a behavioural {Co,S}=A+B+Ci model -> zero mismatches.
- Assert start at the DONE cycle with new A=8'h10, B=8'h20 -> no idle cycle; second done gives S=8'h30, Co=0. start pulses during ADD do not change the result.
- Assert reset at ADD cycle 3 -> S=0, Co=0, busy=0 immediately; no done; the next start computes correctly.
- With SERIAL_ADDER_SUB_EN defined; A=8'h05, B=8'h07, Sub=1 -> S=8'hFE, Co=0. With A=8'h07, B=8'h05 -> S=8'h02, Co=1.
